// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller:
// FSM states, ALU/shifter codes, condition codes, mux selects.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SBC = 4'b0110;
    localparam logic [3:0] ALU_MOV = 4'b0111;

    localparam logic [2:0] SH_LSL  = 3'b000;
    localparam logic [2:0] SH_LSR  = 3'b001;
    localparam logic [2:0] SH_ASR  = 3'b010;
    localparam logic [2:0] SH_ROR  = 3'b011;
    localparam logic [2:0] SH_RORI = 3'b100;

    localparam logic [3:0] C_EQ = 4'h0;
    localparam logic [3:0] C_NE = 4'h1;
    localparam logic [3:0] C_CS = 4'h2;
    localparam logic [3:0] C_CC = 4'h3;
    localparam logic [3:0] C_MI = 4'h4;
    localparam logic [3:0] C_PL = 4'h5;
    localparam logic [3:0] C_VS = 4'h6;
    localparam logic [3:0] C_VC = 4'h7;
    localparam logic [3:0] C_HI = 4'h8;
    localparam logic [3:0] C_LS = 4'h9;
    localparam logic [3:0] C_GE = 4'hA;
    localparam logic [3:0] C_LT = 4'hB;
    localparam logic [3:0] C_GT = 4'hC;
    localparam logic [3:0] C_LE = 4'hD;
    localparam logic [3:0] C_AL = 4'hE;

    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_LR = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic       shift_choice;
        logic [2:0] shift_code;
        logic [4:0] controller_shift;
    } ctrl_t;

    // RSB/RSC/BIC/MVN have no native ALU op; they fall back to
    // the nearest operation and rely on datapath operand handling.
    function automatic logic [3:0] alu_decode(input logic [3:0] funct);
        case (funct)
            4'b0000, 4'b1000, 4'b1110: alu_decode = ALU_AND;
            4'b0001, 4'b1001:          alu_decode = ALU_EOR;
            4'b0010, 4'b0011, 4'b1010: alu_decode = ALU_SUB;
            4'b0100, 4'b1011:          alu_decode = ALU_ADD;
            4'b0101:                   alu_decode = ALU_ADC;
            4'b0110, 4'b0111:          alu_decode = ALU_SBC;
            4'b1100:                   alu_decode = ALU_ORR;
            default:                   alu_decode = ALU_MOV;
        endcase
    endfunction

    // TST/TEQ/CMP/CMN only set flags
    function automatic logic is_cmp(input logic [3:0] funct);
        is_cmp = (funct[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// cond_check: ARM condition evaluation.
// Ports: cond (Instr[31:28]), flags {N,Z,C,V} in; cond_ok out.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ok
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            C_EQ:    cond_ok = z;
            C_NE:    cond_ok = ~z;
            C_CS:    cond_ok = c;
            C_CC:    cond_ok = ~c;
            C_MI:    cond_ok = n;
            C_PL:    cond_ok = ~n;
            C_VS:    cond_ok = v;
            C_VC:    cond_ok = ~v;
            C_HI:    cond_ok = c & ~z;
            C_LS:    cond_ok = ~c | z;
            C_GE:    cond_ok = (n == v);
            C_LT:    cond_ok = (n != v);
            C_GT:    cond_ok = ~z & (n == v);
            C_LE:    cond_ok = z | (n != v);
            default: cond_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle ARM sequencer driving all datapath
// controls from state + Instr; holds NZCV, memory timeout, bus_err.
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  ALUControl,
    output logic        shift_choice,
    output logic [2:0]  shift_code,
    output logic [4:0]  controller_shift,
    output logic        storedCarry,
    output logic        bus_err
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    state_t        state, state_nx;
    logic [3:0]    flags;
    logic [CW-1:0] wait_cnt;
    logic          cond_ok;
    logic          timeout;
    logic          flag_we;
    ctrl_t         c;
    ctrl_t         ctl;
    logic [1:0]    op;
    logic [3:0]    funct;
    logic          unused;

    assign op     = Instr[27:26];
    assign funct  = Instr[24:21];
    assign unused = ^{Instr[19:12], Instr[3:0]};

    cond_check u_cond (
        .cond    (Instr[31:28]),
        .flags   (flags),
        .cond_ok (cond_ok)
    );

    assign flag_we = ((state == EXECR) || (state == EXECI)) & Instr[20];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            flags    <= '0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (mem_ready || timeout)
                wait_cnt <= '0;
            else if (c.mem_req)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                bus_err <= 1'b1;
            if (flag_we)
                flags <= ALUFlags;
        end
    end

    always_comb begin
        state_nx = state;
        c        = '0;
        timeout  = 1'b0;
        unique case (state)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_PC4;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    state_nx   = DECODE;
                end
            end
            DECODE: begin
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                if (!cond_ok)
                    state_nx = FETCH;
                else begin
                    unique case (op)
                        OP_DP:   state_nx = Instr[25] ? EXECI : EXECR;
                        OP_MEM:  state_nx = MEMADR;
                        OP_BR:   state_nx = BRANCH;
                        default: state_nx = HALT;
                    endcase
                end
            end
            MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_MEM;
                state_nx    = Instr[20] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
                if (mem_ready)
                    state_nx = MEMWB;
            end
            MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
                state_nx     = FETCH;
            end
            MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
                if (mem_ready)
                    state_nx = FETCH;
            end
            EXECR, EXECI: begin
                c.alu_src_a   = SRCA_REG;
                c.alu_src_b   = (state == EXECI) ? SRCB_IMM : SRCB_REG;
                c.imm_src     = IMM_DP;
                c.alu_control = alu_decode(funct);
                // immediate operands have no Rs and use the rotate path
                c.shift_code  = (state == EXECI) ? SH_RORI
                                                 : {1'b0, Instr[6:5]};
                c.shift_choice     = (state == EXECR) & Instr[4];
                c.controller_shift = Instr[11:7];
                state_nx = is_cmp(funct) ? FETCH : ALUWB;
            end
            ALUWB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALU;
                state_nx     = FETCH;
            end
            BRANCH: begin
                c.alu_src_a  = SRCA_ALUOUT;
                c.alu_src_b  = SRCB_IMM;
                c.imm_src    = IMM_BR;
                c.result_src = RES_ALU;
                c.pc_write   = 1'b1;
                if (Instr[24]) begin
                    c.reg_write = 1'b1;
                    c.reg_src   = REGSRC_LR;
                end
                state_nx = FETCH;
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase

        timeout = c.mem_req & ~mem_ready
                & (wait_cnt == CW'(MEM_WAIT_MAX - 1));
        if (timeout)
            state_nx = HALT;
    end

    // Reset forces every control low immediately, even mid-access.
    assign ctl = reset ? c : '0;

    assign mem_req          = ctl.mem_req;
    assign MemWrite         = ctl.mem_write;
    assign IRWrite          = ctl.ir_write;
    assign PCWrite          = ctl.pc_write;
    assign RegWrite         = ctl.reg_write;
    assign AdrSrc           = ctl.adr_src;
    assign RegSrc           = ctl.reg_src;
    assign ImmSrc           = ctl.imm_src;
    assign ALUSrcA          = ctl.alu_src_a;
    assign ALUSrcB          = ctl.alu_src_b;
    assign ResultSrc        = ctl.result_src;
    assign ALUControl       = ctl.alu_control;
    assign shift_choice     = ctl.shift_choice;
    assign shift_code       = ctl.shift_code;
    assign controller_shift = ctl.controller_shift;
    assign storedCarry      = flags[1];

endmodule
